// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction-cache miss controller: address split,
// bus command encodings and FSM state type.
package icache_ctrl_pkg;

  localparam int IDX_W  = 7;
  localparam int TAG_W  = 22;
  localparam int OFF_W  = 3;
  localparam int MTAG_W = 4;
  localparam int LINE_W = 32 - OFF_W;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_WAIT = 2'd2
  } ic_state_e;

  function automatic logic [IDX_W-1:0] idxOf(input logic [31:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tagOf(input logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Blocking single-miss controller for a 128 x 64-bit direct-mapped I-cache.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl
  import icache_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [63:0]       fetch_data,
  output logic              fetch_data_valid,
  output logic              fetch_busy,
  output logic [IDX_W-1:0]  cache_rd_idx,
  output logic [TAG_W-1:0]  cache_rd_tag,
  input  logic [63:0]       cache_rd_data,
  input  logic              cache_rd_valid,
  output logic              cache_wr_en,
  output logic [IDX_W-1:0]  cache_wr_idx,
  output logic [TAG_W-1:0]  cache_wr_tag,
  output logic [63:0]       cache_wr_data,
  output logic [1:0]        proc2mem_command,
  output logic [31:0]       proc2mem_addr,
  input  logic [MTAG_W-1:0] mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [MTAG_W-1:0] mem2proc_tag
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  ic_state_e         state_q, state_d;
  logic [LINE_W-1:0] missLine_q, missLine_d;
  logic [MTAG_W-1:0] pendingTag_q, pendingTag_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              busy_q, busy_d;

  logic              hitNow;
  logic              fillNow;
  logic [31:0]       missAddr;
  logic              unusedOffset;

  assign unusedOffset = ^fetch_addr[OFF_W-1:0];
  assign missAddr     = {missLine_q, {OFF_W{1'b0}}};

  // Tag 0 never matches, so a response arriving after reset cannot fill.
  assign hitNow  = (state_q == IC_IDLE) && fetch_req && cache_rd_valid;
  assign fillNow = (state_q == IC_WAIT) && (pendingTag_q != '0) &&
                   (mem2proc_tag == pendingTag_q);

  always_comb begin
    state_d      = state_q;
    missLine_d   = missLine_q;
    pendingTag_d = pendingTag_q;
    case (state_q)
      IC_IDLE: begin
        if (fetch_req && !cache_rd_valid) begin
          missLine_d = fetch_addr[31:OFF_W];
          state_d    = IC_REQ;
        end
      end
      IC_REQ: begin
        if (mem2proc_response != '0) begin
          pendingTag_d = mem2proc_response;
          state_d      = IC_WAIT;
        end
      end
      IC_WAIT: begin
        if (fillNow) begin
          pendingTag_d = '0;
          state_d      = IC_IDLE;
        end
      end
      default: state_d = IC_IDLE;
    endcase
    cmd_d  = (state_d == IC_REQ) ? BUS_LOAD : BUS_NONE;
    busy_d = (state_d != IC_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IC_IDLE;
      missLine_q   <= '0;
      pendingTag_q <= '0;
      cmd_q        <= BUS_NONE;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      missLine_q   <= missLine_d;
      pendingTag_q <= pendingTag_d;
      cmd_q        <= cmd_d;
      busy_q       <= busy_d;
    end
  end

  // The read port follows the live request in IDLE, the miss line otherwise.
  always_comb begin
    if (state_q == IC_IDLE) begin
      cache_rd_idx = idxOf(fetch_addr);
      cache_rd_tag = tagOf(fetch_addr);
    end else begin
      cache_rd_idx = idxOf(missAddr);
      cache_rd_tag = tagOf(missAddr);
    end
  end

  always_comb begin
    fetch_data       = '0;
    fetch_data_valid = 1'b0;
    if (fillNow) begin
      fetch_data       = mem2proc_data;
      fetch_data_valid = 1'b1;
    end else if (hitNow) begin
      fetch_data       = cache_rd_data;
      fetch_data_valid = 1'b1;
    end
  end

  assign cache_wr_en      = fillNow;
  assign cache_wr_idx     = fillNow ? idxOf(missAddr) : '0;
  assign cache_wr_tag     = fillNow ? tagOf(missAddr) : '0;
  assign cache_wr_data    = fillNow ? mem2proc_data : '0;
  assign fetch_busy       = busy_q;
  assign proc2mem_command = cmd_q;
  assign proc2mem_addr    = (cmd_q == BUS_LOAD) ? missAddr : '0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCount_q, missCount_q;
  logic        missStart;

  assign missStart = (state_q == IC_IDLE) && (state_d == IC_REQ);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (hitNow && (hitCount_q != 32'hFFFF_FFFF))
        hitCount_q <= hitCount_q + 32'd1;
      if (missStart && (missCount_q != 32'hFFFF_FFFF))
        missCount_q <= missCount_q + 32'd1;
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed table, reset-mid-miss sequence
// and randomized fetches against a line-level cache model.
module tb_icache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [63:0] fetch_data;
  logic        fetch_data_valid;
  logic        fetch_busy;
  logic [6:0]  cache_rd_idx;
  logic [21:0] cache_rd_tag;
  logic [63:0] cache_rd_data;
  logic        cache_rd_valid;
  logic        cache_wr_en;
  logic [6:0]  cache_wr_idx;
  logic [21:0] cache_wr_tag;
  logic [63:0] cache_wr_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_ctrl dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_data_valid(fetch_data_valid),
    .fetch_busy(fetch_busy),
    .cache_rd_idx(cache_rd_idx), .cache_rd_tag(cache_rd_tag),
    .cache_rd_data(cache_rd_data), .cache_rd_valid(cache_rd_valid),
    .cache_wr_en(cache_wr_en), .cache_wr_idx(cache_wr_idx),
    .cache_wr_tag(cache_wr_tag), .cache_wr_data(cache_wr_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Cache array emulation: combinational read, write on the fill strobe.
  bit          envValid [128];
  logic [21:0] envTag   [128];
  logic [63:0] envData  [128];
  int          wrCount = 0;

  assign cache_rd_valid = envValid[cache_rd_idx] && (envTag[cache_rd_idx] == cache_rd_tag);
  assign cache_rd_data  = envData[cache_rd_idx];

  always @(posedge clock) begin
    if (cache_wr_en) begin
      envValid[cache_wr_idx] <= 1'b1;
      envTag[cache_wr_idx]   <= cache_wr_tag;
      envData[cache_wr_idx]  <= cache_wr_data;
      wrCount                <= wrCount + 1;
    end
  end

  // Reference model: which line each index holds after every completed miss.
  bit          modelValid [128];
  logic [21:0] modelTag   [128];
  logic [63:0] modelData  [128];

  int errors = 0;
  int checks = 0;
  int expHits = 0;
  int expMisses = 0;

  typedef struct {
    logic [31:0] addr;
    int          rejects;
    logic [3:0]  acc;
    int          lat;
    logic [63:0] data;
    logic [3:0]  stray;
    bit          expHit;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input int rejects, input logic [3:0] acc,
                               input int lat, input logic [63:0] data, input logic [3:0] stray,
                               input bit expHit, input logic [63:0] expData, input bit dropReq);
    int wrBefore;
    logic [31:0] lineAddr;
    wrBefore = wrCount;
    lineAddr = {addr[31:3], 3'b000};
    @(negedge clock);
    fetch_req = 1'b1;
    fetch_addr = addr;
    mem2proc_response = 4'd0;
    mem2proc_tag = 4'd0;
    #1;
    checkOutput("detectCmd", proc2mem_command, 2'd0);
    checkOutput("detectWrEn", cache_wr_en, 1'b0);
    checkOutput("detectBusy", fetch_busy, 1'b0);
    if (expHit) begin
      expHits++;
      checkOutput("hitValid", fetch_data_valid, 1'b1);
      checkOutput("hitData", fetch_data, expData);
    end else begin
      expMisses++;
      checkOutput("missDetectValid", fetch_data_valid, 1'b0);
      for (int r = 0; r <= rejects; r++) begin
        @(negedge clock);
        mem2proc_response = (r == rejects) ? acc : 4'd0;
        #1;
        checkOutput("reqCmd", proc2mem_command, 2'd1);
        checkOutput("reqAddr", proc2mem_addr, lineAddr);
        checkOutput("reqBusy", fetch_busy, 1'b1);
        checkOutput("reqValid", fetch_data_valid, 1'b0);
      end
      for (int w = 1; w <= lat; w++) begin
        @(negedge clock);
        mem2proc_response = 4'd0;
        if (dropReq) fetch_req = 1'b0;
        if (w == lat) begin
          mem2proc_tag = acc;
          mem2proc_data = data;
        end else begin
          mem2proc_tag = (w == 1) ? stray : 4'd0;
          mem2proc_data = {$urandom, $urandom};
        end
        #1;
        checkOutput("waitCmd", proc2mem_command, 2'd0);
        checkOutput("waitBusy", fetch_busy, 1'b1);
        if (w == lat) begin
          checkOutput("fillWrEn", cache_wr_en, 1'b1);
          checkOutput("fillWrIdx", cache_wr_idx, addr[9:3]);
          checkOutput("fillWrTag", cache_wr_tag, addr[31:10]);
          checkOutput("fillWrData", cache_wr_data, data);
          checkOutput("fillValid", fetch_data_valid, 1'b1);
          checkOutput("fillData", fetch_data, data);
        end else begin
          checkOutput("waitWrEn", cache_wr_en, 1'b0);
          checkOutput("waitValid", fetch_data_valid, 1'b0);
        end
      end
      modelValid[addr[9:3]] = 1'b1;
      modelTag[addr[9:3]]   = addr[31:10];
      modelData[addr[9:3]]  = data;
    end
    @(negedge clock);
    fetch_req = 1'b0;
    mem2proc_tag = 4'd0;
    mem2proc_response = 4'd0;
    #1;
    checkOutput("doneBusy", fetch_busy, 1'b0);
    checkOutput("wrPulses", wrCount - wrBefore, expHit ? 0 : 1);
  endtask

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0;
    fetch_addr = 32'd0;
    mem2proc_response = 4'd0;
    mem2proc_data = 64'd0;
    mem2proc_tag = 4'd0;

    vecs[0] = '{32'h0000_0408, 0, 4'd3, 5, 64'hDEAD_BEEF_0123_4567, 4'd0, 1'b0, 64'hDEAD_BEEF_0123_4567};
    vecs[1] = '{32'h0000_040C, 0, 4'd0, 1, 64'd0, 4'd0, 1'b1, 64'hDEAD_BEEF_0123_4567};
    vecs[2] = '{32'h0000_1230, 4, 4'd7, 4, 64'h1111_2222_3333_4444, 4'd2, 1'b0, 64'h1111_2222_3333_4444};
    vecs[3] = '{32'h0000_0008, 0, 4'd9, 2, 64'hAAAA_BBBB_CCCC_DDDD, 4'd0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD};
    vecs[4] = '{32'h0000_0408, 1, 4'd12, 3, 64'h5555_6666_7777_8888, 4'd0, 1'b0, 64'h5555_6666_7777_8888};
    vecs[5] = '{32'h0000_0008, 0, 4'd1, 1, 64'h0F0F_1E1E_2D2D_3C3C, 4'd0, 1'b0, 64'h0F0F_1E1E_2D2D_3C3C};
    vecs[6] = '{32'h0000_000C, 0, 4'd0, 1, 64'd0, 4'd0, 1'b1, 64'h0F0F_1E1E_2D2D_3C3C};

    #1;
    checkOutput("rstValid", fetch_data_valid, 1'b0);
    checkOutput("rstBusy", fetch_busy, 1'b0);
    checkOutput("rstCmd", proc2mem_command, 2'd0);
    checkOutput("rstAddr", proc2mem_addr, 32'd0);
    checkOutput("rstWrEn", cache_wr_en, 1'b0);
`ifdef ICACHE_STATS_EN
    checkOutput("rstHits", hit_count, 32'd0);
    checkOutput("rstMisses", miss_count, 32'd0);
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].addr, vecs[i].rejects, vecs[i].acc, vecs[i].lat, vecs[i].data,
                    vecs[i].stray, vecs[i].expHit, vecs[i].expData, 1'b0);
`ifdef ICACHE_STATS_EN
    checkOutput("tableHits", hit_count, expHits);
    checkOutput("tableMisses", miss_count, expMisses);
`endif

    // Reset while waiting for tag 5; the late response must be ignored.
    begin
      int wrBefore;
      wrBefore = wrCount;
      @(negedge clock);
      fetch_req = 1'b1;
      fetch_addr = 32'h0000_2000;
      @(negedge clock);
      mem2proc_response = 4'd5;
      @(negedge clock);
      mem2proc_response = 4'd0;
      #1;
      checkOutput("rmWaitBusy", fetch_busy, 1'b1);
      #2;
      reset = 1'b1;
      fetch_req = 1'b0;
      #1;
      checkOutput("rmRstBusy", fetch_busy, 1'b0);
      checkOutput("rmRstCmd", proc2mem_command, 2'd0);
      @(negedge clock);
      reset = 1'b0;
      mem2proc_tag = 4'd5;
      mem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      checkOutput("rmLateWrEn", cache_wr_en, 1'b0);
      checkOutput("rmLateValid", fetch_data_valid, 1'b0);
      checkOutput("rmLateBusy", fetch_busy, 1'b0);
      @(negedge clock);
      mem2proc_tag = 4'd0;
      #1;
      checkOutput("rmIdleBusy", fetch_busy, 1'b0);
      checkOutput("rmIdleCmd", proc2mem_command, 2'd0);
      checkOutput("rmWrPulses", wrCount - wrBefore, 0);
`ifdef ICACHE_STATS_EN
      checkOutput("rmHits", hit_count, 32'd0);
      checkOutput("rmMisses", miss_count, 32'd0);
`endif
      expHits = 0;
      expMisses = 0;
    end

    // Random fetches over a small set of lines so hits and conflicts recur.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [6:0]  idx;
      logic [21:0] tag;
      logic [3:0]  acc;
      logic [3:0]  stray;
      logic [63:0] d;
      int          lat;
      bit          hit;
      idx = 7'($urandom_range(10, 13));
      tag = 22'($urandom_range(16, 18));
      a = {tag, idx, 3'($urandom_range(0, 7))};
      acc = 4'($urandom_range(1, 15));
      lat = $urandom_range(1, 4);
      stray = (lat >= 2) ? 4'(((acc + 4'($urandom_range(1, 14))) % 16)) : 4'd0;
      if (stray == acc) stray = 4'd0;
      d = {$urandom, $urandom};
      hit = modelValid[idx] && (modelTag[idx] == tag);
      applyStimulus(a, $urandom_range(0, 2), acc, lat, d, stray, hit,
                    hit ? modelData[idx] : d, 1'($urandom_range(0, 1)));
    end
`ifdef ICACHE_STATS_EN
    checkOutput("randHits", hit_count, expHits);
    checkOutput("randMisses", miss_count, expMisses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
